fifo_read_streamer: RTL and testbench
=====================================

# fifo_read_streamer

Read-side controller for the project FIFO. It pops a programmed number of words from the FIFO's synchronous read port and presents them on a valid/ready stream. A 2-entry skid buffer absorbs the one-cycle FIFO read latency, so the block sustains one word per cycle under continuous `m_ready` and never overruns under backpressure. It is the consumer counterpart of the FIFO write-side stimulus and sits between the FIFO and any downstream sink.

## Interface
- DATA_WIDTH, 8, FIFO word width
- ADDR_WIDTH, 5, FIFO address width; burst and count fields are ADDR_WIDTH+1 bits (max 32 words = DEPTH)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  begin a burst; sampled only in IDLE
- burst_len  in  ADDR_WIDTH+1  words to read, sampled with start
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  FIFO pop request, combinational from registered state
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid in the cycle after an accepted fifo_rd
- m_data  out  DATA_WIDTH  stream data (skid head)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- rd_count  out  ADDR_WIDTH+1  words delivered (handshaked) in current burst
- busy  out  1  state != IDLE
- done  out  1  one-cycle burst-complete pulse

## Operation
- States: IDLE, RUN (issuing pops), DRAIN (all pops issued, emptying skid), DONE (1 cycle).
- IDLE: start=1 latches burst_len, clears rd_count and issued counter. burst_len≠0 → RUN; burst_len=0 → DONE directly, no fifo_rd.
- fifo_rd = RUN && !fifo_empty && (occ + inflight − pop) < 2, where occ = skid entries (0..2), inflight = fifo_rd from previous cycle, pop = m_valid && m_ready.
- fifo_rd never asserts while fifo_empty=1 (no underflow) or outside RUN.
- Each fifo_rd increments issued; issued == latched burst_len → RUN to DRAIN on the same edge.
- fifo_dout is written into the skid tail at the end of the cycle following fifo_rd. The skid is FIFO-ordered and m_data = head entry.
- m_valid = occ≠0. While m_valid=1 && m_ready=0, m_data is held stable.
- Each handshake increments rd_count and pops the skid head.
- DRAIN → DONE when occ==0 && inflight==0 after the edge; done=1 in DONE only. DONE → IDLE unconditionally.
- start while busy is ignored, and burst_len is not re-sampled.
- Reset values: state IDLE, fifo_rd=0, m_valid=0, m_data=0, rd_count=0, busy=0, done=0; skid and counters cleared.

## Timing
- Cycle 0: start=1 sampled. Cycle 1: first fifo_rd if not empty. Cycle 2: fifo_dout present, captured. Cycle 3: m_valid=1.
- Latency from start to first m_valid is 3 cycles with a non-empty FIFO.
- Throughput with m_ready held at 1: one word per cycle, back-to-back fifo_rd.
- done is high exactly in the cycle after the final handshake clears the skid.
- Asynchronous reset mid-burst: outputs go to reset values immediately, with no clock needed.
  - Words popped but not delivered are discarded.
  - The first rising edge after rst deasserts sees IDLE.

## Test plan
- Reset: rst=0 with random inputs → fifo_rd=0, m_valid=0, m_data=0, rd_count=0, busy=0, done=0.
- Full-rate burst: FIFO holds 0xA0..0xA3, burst_len=4, m_ready=1, start at cycle 0 → fifo_rd in cycles 1–4; m_valid with A0,A1,A2,A3 in cycles 3–6; done=1 in cycle 7; rd_count=4; busy=0 in cycle 8.
- Backpressure: 8 words loaded, burst_len=8, m_ready=0 for cycles 0–9 → exactly 2 fifo_rd issued, m_data held at first word. Then m_ready=1 → all 8 words in order, no loss or duplication.
- Empty stall: start with fifo_empty=1 → fifo_rd stays 0, state RUN, busy=1. Push 0x5C → fifo_rd next cycle, 0x5C delivered.
- Edge cases:
  - burst_len=0 → done=1 in cycle 1, no fifo_rd.
  - start pulsed during a busy burst → ignored, rd_count unaffected.
  - burst_len=32 from a full FIFO → 32 words delivered, fifo_empty=1 at end.
- Reset mid-burst: rst=0 at cycle 4 of an 8-word burst → immediate reset values. A new start after release runs normally from the next FIFO word.

Source files
------------

// File: rtl/fifo_read_streamer_if.sv
// fifo_read_streamer_if
//   Bundles the two handshakes of the FIFO read streamer: the synchronous
//   FIFO read port and the outgoing valid/ready stream.
//   master : the streamer (drives fifo_rd, m_data, m_valid)
//   slave  : the environment (FIFO + downstream sink)
//   Signals:
//     fifo_empty  FIFO empty flag
//     fifo_rd     FIFO pop request
//     fifo_dout   FIFO read data, valid the cycle after an accepted pop
//     m_data      stream data
//     m_valid     stream valid
//     m_ready     stream ready
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd, m_data, m_valid
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer
//   Pops a programmed number of words from a FIFO with a one-cycle read
//   latency and presents them on a valid/ready stream. A 2-entry skid buffer
//   holds words that have come out of the FIFO but not yet been accepted
//   downstream, so the block runs at one word per cycle and never overruns
//   under backpressure.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous reset, active low
//     start      begin a burst (only honoured while idle)
//     burst_len  number of words to read, captured with start
//     bus        FIFO read port + output stream (master modport)
//     rd_count   words handshaked in the current burst
//     busy       high whenever a burst is in progress
//     done       one-cycle pulse when a burst has fully drained
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  fifo_read_streamer_if.master  bus,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   burst_q, burst_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   rd_count_q, rd_count_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;

  logic                  pop;
  logic                  push;
  logic                  rd_en;
  logic [2:0]            fill;

  // Pop request: only in RUN, never into an empty FIFO, and only when the
  // words already held or on their way (minus the one leaving this cycle)
  // leave room for one more in the skid.
  always_comb begin
    pop   = (occ_q != 2'd0) && bus.m_ready;
    push  = inflight_q;
    fill  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en = (state_q == RUN) && !bus.fifo_empty && (fill < 3'd2);
  end

  // Skid buffer: skid0 is the head shown on m_data, skid1 the second entry.
  // Data returned by the FIFO is appended at the tail; a handshake shifts
  // the head out. Push and pop may happen in the same cycle.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    occ_d      = occ_q;
    inflight_d = rd_en;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) skid0_d = bus.fifo_dout;
        else               skid1_d = bus.fifo_dout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        skid0_d = skid1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          skid0_d = bus.fifo_dout;
        end else begin
          skid0_d = skid1_q;
          skid1_d = bus.fifo_dout;
        end
      end
      default: ;
    endcase
  end

  // Burst sequencing. RUN leaves for DRAIN on the edge that issues the last
  // pop; DRAIN waits until nothing is held or in flight after the edge.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    issued_d   = issued_q;
    rd_count_d = pop ? rd_count_q + CNT_ONE : rd_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          burst_d    = burst_len;
          issued_d   = '0;
          rd_count_d = '0;
          state_d    = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en) begin
          issued_d = issued_q + CNT_ONE;
          if (issued_d == burst_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_d == 2'd0) && !inflight_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.fifo_rd = rd_en;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = skid0_q;
  assign rd_count    = rd_count_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer
//   Directed and randomized bench for fifo_read_streamer. A queue models the
//   FIFO contents; every word the DUT pops is expected to appear on the
//   stream exactly once, in order, with the stream rules (hold under
//   backpressure, at most two words outstanding, no pop from an empty FIFO)
//   checked every cycle.
module tb_fifo_read_streamer;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   burst_len;
  logic [AW:0]   rd_count;
  logic          busy;
  logic          done;

  fifo_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

  fifo_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .burst_len(burst_len),
    .bus(bus.master),
    .rd_count(rd_count),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // FIFO contents, words popped but not yet delivered, pending writes,
  // and the log of delivered words
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] hs_log[$];

  int checks   = 0;
  int errors   = 0;
  int rd_total = 0;
  int hs_total = 0;

  logic          s_rd, s_valid, s_busy, s_done;
  logic [DW-1:0] s_data;
  logic [AW:0]   s_count;
  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [DW-1:0] p_data  = '0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs just after the inputs settle, apply
  // the per-cycle stream rules, then let the FIFO model react to the edge.
  task automatic step();
    logic [DW-1:0] w;
    int hs;
    #1;
    s_rd    = bus.fifo_rd;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_busy  = busy;
    s_done  = done;
    s_count = rd_count;
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      hs = (s_valid && bus.m_ready) ? 1 : 0;
      if (s_rd) begin
        check_output("rd_while_empty", 32'(fifo_q.size() == 0), 32'd0);
        check_output("overrun", 32'((exp_q.size() - hs) >= 2), 32'd0);
        rd_total++;
      end
      if (p_valid && !p_ready) begin
        check_output("hold_valid", 32'(s_valid), 32'd1);
        check_output("hold_data", 32'(s_data), 32'(p_data));
      end
      if (s_valid && exp_q.size() == 0) begin
        check_output("valid_no_word", 32'(s_valid), 32'd0);
      end else if (hs != 0) begin
        w = exp_q.pop_front();
        check_output("stream_data", 32'(s_data), 32'(w));
        hs_log.push_back(s_data);
        hs_total++;
      end
      p_valid = s_valid;
      p_ready = bus.m_ready;
      p_data  = s_data;
    end
    @(posedge clk);
    if (rst_n && s_rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      bus.fifo_dout <= w;
      exp_q.push_back(w);
    end
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    bus.fifo_empty <= (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  // Load a word into the FIFO while the DUT is idle
  task automatic preload(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty <= 1'b0;
  endtask

  // Write a word into the FIFO at the next clock edge
  task automatic push(input logic [DW-1:0] w);
    pend_q.push_back(w);
  endtask

  task automatic start_burst(input int len);
    start     = 1'b1;
    burst_len = (AW+1)'(len);
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rand_ready, output int cycles);
    cycles = 0;
    do begin
      if (rand_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
      step();
      cycles++;
    end while (!s_done && cycles < bound);
    check_output("done_within_bound", 32'(s_done), 32'd1);
  endtask

  task automatic check_order(input string tag, input logic [DW-1:0] words[$]);
    int mism;
    mism = 0;
    for (int i = 0; i < words.size(); i++) begin
      if (i >= hs_log.size() || hs_log[i] !== words[i]) mism++;
    end
    check_output(tag, 32'(mism), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_fifo_rd"},  32'(s_rd),    32'd0);
    check_output({tag, "_m_valid"},  32'(s_valid), 32'd0);
    check_output({tag, "_m_data"},   32'(s_data),  32'd0);
    check_output({tag, "_rd_count"}, 32'(s_count), 32'd0);
    check_output({tag, "_busy"},     32'(s_busy),  32'd0);
    check_output({tag, "_done"},     32'(s_done),  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] words[$];
    int n0;
    int cyc;
    int len;

    rst_n          = 1'b0;
    start          = 1'b0;
    burst_len      = '0;
    bus.m_ready    = 1'b0;
    bus.fifo_dout  <= '0;
    bus.fifo_empty <= 1'b1;
    @(negedge clk);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start       = 1'($urandom);
      burst_len   = (AW+1)'($urandom);
      bus.m_ready = 1'($urandom);
      step();
      check_reset_values("rst");
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    check_output("idle_busy", 32'(s_busy), 32'd0);

    // Full-rate burst of four words
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) preload(8'hA0 + 8'(i));
    hs_log.delete();
    start_burst(4);
    check_output("fr_c0_rd", 32'(s_rd), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      step();
      check_output("fr_rd",    32'(s_rd),    32'(c >= 1 && c <= 4));
      check_output("fr_valid", 32'(s_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check_output("fr_data", 32'(s_data), 32'(8'hA0 + 8'(c - 3)));
      check_output("fr_done",  32'(s_done),  32'(c == 7));
      check_output("fr_busy",  32'(s_busy),  32'(c <= 7));
      if (c == 7) check_output("fr_count", 32'(s_count), 32'd4);
    end

    // Backpressure: stream stalled for cycles 0-9
    bus.m_ready = 1'b0;
    words.delete();
    for (int i = 0; i < 8; i++) begin
      words.push_back(8'($urandom));
      preload(words[i]);
    end
    hs_log.delete();
    n0 = rd_total;
    start_burst(8);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c >= 3) begin
        check_output("bp_valid", 32'(s_valid), 32'd1);
        check_output("bp_head",  32'(s_data),  32'(words[0]));
      end
    end
    check_output("bp_rd_issued", 32'(rd_total - n0), 32'd2);
    bus.m_ready = 1'b1;
    wait_done(40, 1'b0, cyc);
    check_output("bp_count", 32'(s_count), 32'd8);
    check_output("bp_delivered", 32'(hs_log.size()), 32'd8);
    check_order("bp_order", words);

    // Empty FIFO stall, then a single word arrives
    hs_log.delete();
    start_burst(1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check_output("stall_rd",   32'(s_rd),   32'd0);
      check_output("stall_busy", 32'(s_busy), 32'd1);
      check_output("stall_done", 32'(s_done), 32'd0);
    end
    push(8'h5C);
    step();
    check_output("stall_rd_before_write", 32'(s_rd), 32'd0);
    step();
    check_output("stall_rd_after_write", 32'(s_rd), 32'd1);
    wait_done(10, 1'b0, cyc);
    check_output("stall_word", 32'(hs_log.size() > 0 ? hs_log[0] : 8'h00), 32'h5C);

    // Zero-length burst with data waiting in the FIFO
    preload(8'h33);
    n0 = rd_total;
    start_burst(0);
    step();
    check_output("zero_done", 32'(s_done), 32'd1);
    check_output("zero_rd",   32'(s_rd),   32'd0);
    check_output("zero_busy", 32'(s_busy), 32'd1);
    step();
    check_output("zero_done_gone", 32'(s_done), 32'd0);
    check_output("zero_idle",      32'(s_busy), 32'd0);
    check_output("zero_no_pops",   32'(rd_total - n0), 32'd0);

    // Start pulses during a busy burst are ignored
    words.delete();
    words.push_back(8'h33);
    for (int i = 0; i < 7; i++) begin
      words.push_back(8'($urandom));
      preload(words[i + 1]);
    end
    bus.m_ready = 1'b1;
    hs_log.delete();
    n0 = rd_total;
    start_burst(6);
    step();
    start     = 1'b1;
    burst_len = (AW+1)'(3);
    step();
    start     = 1'b0;
    step();
    start     = 1'b1;
    burst_len = (AW+1)'(2);
    step();
    start     = 1'b0;
    wait_done(40, 1'b1, cyc);
    check_output("ps_count", 32'(s_count), 32'd6);
    check_output("ps_pops", 32'(rd_total - n0), 32'd6);
    check_output("ps_delivered", 32'(hs_log.size()), 32'd6);
    words = words[0:5];
    check_order("ps_order", words);
    step();
    check_output("ps_idle", 32'(s_busy), 32'd0);
    // Two spare words remain; drain them
    start_burst(2);
    wait_done(20, 1'b0, cyc);

    // Maximum burst from a full FIFO with random backpressure
    words.delete();
    for (int i = 0; i < 32; i++) begin
      words.push_back(8'($urandom));
      preload(words[i]);
    end
    hs_log.delete();
    n0 = rd_total;
    start_burst(32);
    wait_done(400, 1'b1, cyc);
    check_output("b32_count", 32'(s_count), 32'd32);
    check_output("b32_pops", 32'(rd_total - n0), 32'd32);
    check_output("b32_fifo_empty", 32'(bus.fifo_empty), 32'd1);
    check_order("b32_order", words);

    // Random bursts with random backpressure
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < len; i++) begin
        words.push_back(8'($urandom));
        preload(words[i]);
      end
      hs_log.delete();
      start_burst(len);
      wait_done(200, 1'b1, cyc);
      check_output("rnd_count", 32'(s_count), 32'(len));
      check_order("rnd_order", words);
    end

    // Reset in cycle 4 of an eight-word burst
    bus.m_ready = 1'b1;
    words.delete();
    for (int i = 0; i < 10; i++) begin
      words.push_back(8'($urandom));
      preload(words[i]);
    end
    start_burst(8);
    for (int c = 1; c <= 3; c++) step();
    rst_n = 1'b0;
    step();
    check_reset_values("mid_rst");
    rst_n = 1'b1;
    step();
    hs_log.delete();
    start_burst(2);
    wait_done(20, 1'b0, cyc);
    check_output("rr_count", 32'(s_count), 32'd2);
    check_output("rr_word0", 32'(hs_log.size() > 0 ? hs_log[0] : 8'h00), 32'(words[3]));
    check_output("rr_word1", 32'(hs_log.size() > 1 ? hs_log[1] : 8'h00), 32'(words[4]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
